// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline constants and fetch-state type
// Contents: LEN (datapath width), NOP_WORD, HALT_WORD, fetch_state_t.
package mips_pkg;

    localparam int LEN = 32;

    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/instruction_memory.sv
// rtl/instruction_memory.sv - instruction RAM, one sync write port, one combinational read port
// Ports:
//   i_clk    clock, rising edge (write port only)
//   i_we     loader write strobe
//   i_waddr  loader word address
//   i_wdata  loader data
//   i_raddr  fetch word address
//   o_rdata  fetch data (combinational; shows the old word during a write to the same address)
module instruction_memory #(
    parameter int LEN     = 32,
    parameter int NB_ADDR = 10
) (
    input  logic               i_clk,
    input  logic               i_we,
    input  logic [NB_ADDR-1:0] i_waddr,
    input  logic [LEN-1:0]     i_wdata,
    input  logic [NB_ADDR-1:0] i_raddr,
    output logic [LEN-1:0]     o_rdata
);

    // Contents are deliberately not reset: the loader owns initialisation.
    logic [LEN-1:0] mem [2**NB_ADDR];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/seg_instruction_fetch.sv
// rtl/seg_instruction_fetch.sv - MIPS IF stage: PC, next-PC select, instruction memory, IF/ID latch
// Optional feature macro: IF_HALT_DETECT_EN (halt-word detection freezes fetch).
// Ports:
//   i_clk, i_rst (async active-low)    clock / reset
//   i_enable                           debug step enable; 0 freezes all state
//   i_pc_write                         0 = hazard stall, PC and IF/ID hold
//   i_flush                            load NOP into IF/ID
//   i_jump, i_PC_dir_jump              jump redirect from decode
//   i_branch_taken, i_PC_branch        branch redirect from execute (wins over jump)
//   i_imem_we/_waddr/_wdata            instruction loader write port
//   o_PC, o_instruction                IF/ID latch: PC+4 and instruction
//   o_pc_current                       live PC register
//   o_halt                             fetch halted
module seg_instruction_fetch
    import mips_pkg::*;
#(
    parameter int LEN          = mips_pkg::LEN,
    parameter int NB_IMEM_ADDR = 10
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_enable,
    input  logic                    i_pc_write,
    input  logic                    i_flush,
    input  logic                    i_jump,
    input  logic [LEN-1:0]          i_PC_dir_jump,
    input  logic                    i_branch_taken,
    input  logic [LEN-1:0]          i_PC_branch,
    input  logic                    i_imem_we,
    input  logic [NB_IMEM_ADDR-1:0] i_imem_waddr,
    input  logic [LEN-1:0]          i_imem_wdata,
    output logic [LEN-1:0]          o_PC,
    output logic [LEN-1:0]          o_instruction,
    output logic [LEN-1:0]          o_pc_current,
    output logic                    o_halt
);

    logic [LEN-1:0] pc_q;
    logic [LEN-1:0] ifid_pc_q;
    logic [LEN-1:0] ifid_instr_q;
    logic [LEN-1:0] pc_plus4;
    logic [LEN-1:0] next_pc;
    logic [LEN-1:0] fetched;
    logic           advance;
    logic           halted;

    instruction_memory #(
        .LEN     (LEN),
        .NB_ADDR (NB_IMEM_ADDR)
    ) u_imem (
        .i_clk   (i_clk),
        .i_we    (i_imem_we),
        .i_waddr (i_imem_waddr),
        .i_wdata (i_imem_wdata),
        .i_raddr (pc_q[NB_IMEM_ADDR+1:2]),
        .o_rdata (fetched)
    );

    assign pc_plus4 = pc_q + LEN'(4);

    // Branch resolves later in the pipe than jump, so it is the older
    // instruction and must win. Targets are forced word-aligned.
    always_comb begin
        next_pc = pc_plus4;
        if (i_branch_taken) begin
            next_pc = i_PC_branch & ~LEN'(3);
        end else if (i_jump) begin
            next_pc = i_PC_dir_jump & ~LEN'(3);
        end
    end

`ifdef IF_HALT_DETECT_EN
    fetch_state_t state_q;
    fetch_state_t state_d;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // A halt word fetched on a flushed or redirected cycle is wrong-path
    // and must not stop the machine.
    always_comb begin
        state_d = state_q;
        if (advance && !i_flush && !i_jump && !i_branch_taken &&
            fetched == LEN'(HALT_WORD)) begin
            state_d = ST_HALTED;
        end
    end

    assign halted = (state_q == ST_HALTED);
`else
    assign halted = 1'b0;
`endif

    assign advance = i_enable && i_pc_write && !halted;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            pc_q         <= '0;
            ifid_pc_q    <= '0;
            ifid_instr_q <= '0;
        end else if (advance) begin
            pc_q <= next_pc;
            if (i_flush) begin
                ifid_pc_q    <= '0;
                ifid_instr_q <= LEN'(NOP_WORD);
            end else begin
                ifid_pc_q    <= pc_plus4;
                ifid_instr_q <= fetched;
            end
        end else if (i_enable && halted) begin
            // Keep bubbling NOPs downstream behind the halt word.
            ifid_pc_q    <= '0;
            ifid_instr_q <= LEN'(NOP_WORD);
        end
    end

    assign o_PC          = ifid_pc_q;
    assign o_instruction = ifid_instr_q;
    assign o_pc_current  = pc_q;
    assign o_halt        = halted;

endmodule

// File: tb/tb_seg_instruction_fetch.sv
// tb/tb_seg_instruction_fetch.sv - directed self-checking bench for seg_instruction_fetch
module tb_seg_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        pc_write;
    logic        flush;
    logic        jump;
    logic [31:0] pc_dir_jump;
    logic        branch_taken;
    logic [31:0] pc_branch;
    logic        imem_we;
    logic [9:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic [31:0] o_pc;
    logic [31:0] o_instruction;
    logic [31:0] o_pc_current;
    logic        o_halt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seg_instruction_fetch dut (
        .i_clk          (clk),
        .i_rst          (rst_n),
        .i_enable       (enable),
        .i_pc_write     (pc_write),
        .i_flush        (flush),
        .i_jump         (jump),
        .i_PC_dir_jump  (pc_dir_jump),
        .i_branch_taken (branch_taken),
        .i_PC_branch    (pc_branch),
        .i_imem_we      (imem_we),
        .i_imem_waddr   (imem_waddr),
        .i_imem_wdata   (imem_wdata),
        .o_PC           (o_pc),
        .o_instruction  (o_instruction),
        .o_pc_current   (o_pc_current),
        .o_halt         (o_halt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load(input logic [9:0] addr, input logic [31:0] data);
        imem_we    = 1'b1;
        imem_waddr = addr;
        imem_wdata = data;
        tick();
        imem_we    = 1'b0;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] pc,
                              input logic [31:0] instr, input logic [31:0] pc_cur,
                              input logic halt);
        check({tag, ".o_PC"}, o_pc, pc);
        check({tag, ".instr"}, o_instruction, instr);
        check({tag, ".pc_cur"}, o_pc_current, pc_cur);
        check({tag, ".halt"}, {31'd0, o_halt}, {31'd0, halt});
    endtask

    initial begin
        rst_n        = 1'b0;
        enable       = 1'b0;
        pc_write     = 1'b1;
        flush        = 1'b0;
        jump         = 1'b0;
        pc_dir_jump  = '0;
        branch_taken = 1'b0;
        pc_branch    = '0;
        imem_we      = 1'b0;
        imem_waddr   = '0;
        imem_wdata   = '0;
        @(negedge clk);

        check_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0);

        load(10'd0,  32'h2001_0005);
        load(10'd1,  32'h2002_0007);
        load(10'd2,  32'h2003_0009);
        load(10'd3,  32'h2004_000B);
        load(10'd4,  32'hFFFF_FFFF);
        load(10'd5,  32'h2008_0003);
        load(10'd32, 32'h2005_000D);
        load(10'd33, 32'hFFFF_FFFF);
        load(10'd34, 32'h2006_0001);
        load(10'd35, 32'h2007_0002);

        rst_n = 1'b1;
        tick();
        check_ifid("disabled", 32'h0, 32'h0, 32'h0, 1'b0);

        enable = 1'b1;
        tick();
        check_ifid("fetch0", 32'h4, 32'h2001_0005, 32'h4, 1'b0);
        tick();
        check_ifid("fetch1", 32'h8, 32'h2002_0007, 32'h8, 1'b0);

        // Stall two cycles; a jump during stall must be ignored.
        pc_write    = 1'b0;
        jump        = 1'b1;
        pc_dir_jump = 32'h40;
        tick();
        check_ifid("stall1", 32'h8, 32'h2002_0007, 32'h8, 1'b0);
        jump = 1'b0;
        tick();
        check_ifid("stall2", 32'h8, 32'h2002_0007, 32'h8, 1'b0);
        pc_write = 1'b1;
        tick();
        check_ifid("resume", 32'hC, 32'h2003_0009, 32'hC, 1'b0);

        // Branch beats jump; misaligned target bits are cleared.
        jump         = 1'b1;
        pc_dir_jump  = 32'h40;
        branch_taken = 1'b1;
        pc_branch    = 32'h83;
        tick();
        check_ifid("redirect", 32'h10, 32'h2004_000B, 32'h80, 1'b0);
        jump         = 1'b0;
        branch_taken = 1'b0;

        flush = 1'b1;
        tick();
        check_ifid("flush", 32'h0, 32'h0, 32'h84, 1'b0);
        // Halt word at 0x84 fetched under flush is squashed.
        tick();
        check_ifid("halt_squash", 32'h0, 32'h0, 32'h88, 1'b0);
        flush = 1'b0;
        tick();
        check_ifid("after_flush", 32'h8C, 32'h2006_0001, 32'h8C, 1'b0);

        jump        = 1'b1;
        pc_dir_jump = 32'h10;
        tick();
        check_ifid("jump", 32'h90, 32'h2007_0002, 32'h10, 1'b0);
        jump = 1'b0;

`ifdef IF_HALT_DETECT_EN
        tick();
        check_ifid("halt_in", 32'h14, 32'hFFFF_FFFF, 32'h14, 1'b1);
        tick();
        check_ifid("halted_nop", 32'h0, 32'h0, 32'h14, 1'b1);
        tick();
        check_ifid("halted_nop2", 32'h0, 32'h0, 32'h14, 1'b1);
`else
        tick();
        check_ifid("halt_plain", 32'h14, 32'hFFFF_FFFF, 32'h14, 1'b0);
        tick();
        check_ifid("past_halt", 32'h18, 32'h2008_0003, 32'h18, 1'b0);
`endif

        // Asynchronous reset while frozen.
        enable = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_ifid("async_rst", 32'h0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b1;
        tick();
        check_ifid("post_rst", 32'h4, 32'h2001_0005, 32'h4, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
